// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue with lane steering, back-pressure and load-conflict detect
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [31:0]                st_data,
    input  logic [1:0]                 st_size,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_conflict,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [31:0]                mem_wd,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ready,
    output logic                       st_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [DEPTH-1:0] ent_valid;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [31:0]      ent_wd   [DEPTH];
    logic [3:0]       ent_be   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic          full;
    logic          legal;
    logic          accept;
    logic          reject;
    logic          retire;
    logic [31:0]   steer_wd;
    logic [3:0]    steer_be;
    logic [AW-1:0] word_addr;
    logic          hit;

    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // Misaligned halfwords/words and the reserved size code are refused, never split.
    always_comb begin
        legal = 1'b0;
        case (st_size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = !st_addr[0];
            SZ_WORD: legal = (st_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign accept = st_valid && st_ready && legal;
    assign reject = st_valid && st_ready && !legal;
    assign retire = mem_we && mem_ready;

    // Replicate the narrow datum across every lane so the byte enables alone select it.
    always_comb begin
        steer_wd = st_data;
        steer_be = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                steer_wd = {4{st_data[7:0]}};
                steer_be = 4'b0001 << st_addr[1:0];
            end
            SZ_HALF: begin
                steer_wd = {2{st_data[15:0]}};
                steer_be = 4'b0011 << st_addr[1:0];
            end
            default: begin
                steer_wd = st_data;
                steer_be = 4'b1111;
            end
        endcase
    end

    assign word_addr = {st_addr[AW-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            st_err    <= 1'b0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_wd[i]   <= '0;
                ent_be[i]   <= '0;
            end
        end else begin
            st_err <= reject;
            // Head and tail never coincide when both fire, so the two updates are independent.
            if (retire) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (accept) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= word_addr;
                ent_wd[tail]    <= steer_wd;
                ent_be[tail]    <= steer_be;
                tail            <= tail + 1'b1;
            end
            case ({accept, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign mem_we   = !empty;
    assign mem_addr = ent_addr[head];
    assign mem_wd   = ent_wd[head];
    assign mem_be   = ent_be[head];

    // Word-granular match against registered entries only; a same-edge enqueue is not seen.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i][AW-1:2] == ld_addr[AW-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_conflict = ld_valid && hit;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic          st_err;
    logic [2:0]    count;
    logic          empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors;
    int   miscompares;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_be(mem_be),
        .mem_ready(mem_ready),
        .st_err(st_err), .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every memory write the DUT performs is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL drain_unexpected got addr=%h wd=%h be=%b, none expected",
                         mem_addr, mem_wd, mem_be);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr !== mon_e.addr || mem_wd !== mon_e.wd || mem_be !== mon_e.be) begin
                    miscompares++;
                    $display("FAIL drain_data got addr=%h wd=%h be=%b, want addr=%h wd=%h be=%b",
                             mem_addr, mem_wd, mem_be, mon_e.addr, mon_e.wd, mon_e.be);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e.addr = a;
        e.wd   = wd;
        e.be   = be;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_we !== 1'b0 || st_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got count=%0d empty=%b st_ready=%b mem_we=%b st_err=%b, want 0 1 1 0 0",
                     count, empty, st_ready, mem_we, st_err);
        end
    endtask

    task automatic test_word();
        tick();
        mem_ready = 1'b1;
        drive(32'h14, 32'hdeadc0de, 2'b10);
        push_exp(32'h14, 32'hdeadc0de, 4'b1111);
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL word_pre got mem_we=%b, want 0", mem_we);
        end
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h14 || mem_be !== 4'b1111 || mem_wd !== 32'hdeadc0de) begin
            miscompares++;
            $display("FAIL word_latency got we=%b addr=%h be=%b wd=%h, want 1 00000014 1111 deadc0de",
                     mem_we, mem_addr, mem_be, mem_wd);
        end
        tick();
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL word_retire got empty=%b, want 1", empty);
        end
    endtask

    task automatic test_byte();
        drive(32'h2b, 32'h000000ab, 2'b00);
        push_exp(32'h28, 32'habababab, 4'b1000);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_addr !== 32'h28 || mem_be !== 4'b1000 || mem_wd !== 32'habababab) begin
            miscompares++;
            $display("FAIL byte_lane got addr=%h be=%b wd=%h, want 00000028 1000 abababab",
                     mem_addr, mem_be, mem_wd);
        end
        tick();
    endtask

    task automatic test_half();
        drive(32'h22, 32'h0000beef, 2'b01);
        push_exp(32'h20, 32'hbeefbeef, 4'b1100);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_be !== 4'b1100 || mem_wd !== 32'hbeefbeef) begin
            miscompares++;
            $display("FAIL half_lane got be=%b wd=%h, want 1100 beefbeef", mem_be, mem_wd);
        end
        tick();
    endtask

    task automatic test_full();
        int n;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 2'b10);
            if (i < 4) push_exp(32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'b1111);
            if (i == 4) begin
                @(negedge clk);
                vectors++;
                if (count !== 3'd4 || st_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_state got count=%0d st_ready=%b, want 4 0", count, st_ready);
                end
            end
            tick();
        end
        st_valid = 1'b0;
        vectors++;
        if (st_err !== 1'b0 || count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_hold got st_err=%b count=%0d, want 0 4", st_err, count);
        end
        mem_ready = 1'b1;
        n = 0;
        while (count !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL full_drain got %0d cycles to empty, want 4", n);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL full_order got %0d pending expectations, want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h200 + 32'(i), 32'h0000_00c0 + 32'(i), 2'b00);
            push_exp(32'h200, {4{8'hc0 + 8'(i)}}, 4'b0001 << i);
            tick();
            vectors++;
            if (count !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_count got %0d, want 1 at store %0d", count, i);
            end
        end
        st_valid = 1'b0;
        tick();
        vectors++;
        if (empty !== 1'b1 || sb.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_drain got empty=%b pending=%0d, want 1 0", empty, sb.size());
        end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h03; sizes[0] = 2'b01;
        addrs[1] = 32'h06; sizes[1] = 2'b10;
        addrs[2] = 32'h08; sizes[2] = 2'b11;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 32'h5555_aaaa, sizes[i]);
            tick();
            st_valid = 1'b0;
            vectors++;
            if (st_err !== 1'b1 || count !== 3'd0 || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_pulse case %0d got st_err=%b count=%0d mem_we=%b, want 1 0 0",
                         i, st_err, count, mem_we);
            end
            tick();
            vectors++;
            if (st_err !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_width case %0d got st_err=%b, want 0", i, st_err);
            end
        end
    endtask

    task automatic test_conflict();
        mem_ready = 1'b0;
        drive(32'h40, 32'h12345678, 2'b10);
        ld_valid = 1'b1;
        ld_addr  = 32'h40;
        #1;
        vectors++;
        if (ld_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_same_edge got %b, want 0", ld_conflict);
        end
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h42;
        #1;
        vectors++;
        if (ld_conflict !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_hit got %b, want 1", ld_conflict);
        end
        ld_addr = 32'h44;
        #1;
        vectors++;
        if (ld_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_miss got %b, want 0", ld_conflict);
        end
        ld_addr = 32'h40;
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== 3'd0 || ld_conflict !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got count=%0d ld_conflict=%b mem_we=%b, want 0 0 0",
                     count, ld_conflict, mem_we);
        end
        tick();
        rst = 1'b0;
        ld_valid = 1'b0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        st_valid    = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        st_size     = 2'b00;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        mem_ready   = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_full();
        test_back_to_back();
        test_illegal();
        test_conflict();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised, in-order store queue between the RISC-V datapath store path and the data memory write port.
- Generalises the single-cycle word-store path to byte, halfword and word stores, with byte-enables and lane steering.
- Provides configurable queue depth, memory back-pressure and a load-conflict indication for the hazard unit.
- Stores drain to memory one per cycle, oldest first.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the datapath.
- st_addr  in  AW  store byte address.
- st_data  in  32  store data, right-aligned (rs2 value).
- st_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- st_ready  out  1  queue can accept a store; equals not full.
- ld_valid  in  1  a load is being issued this cycle.
- ld_addr  in  AW  load byte address.
- ld_conflict  out  1  load word address matches a pending entry.
- mem_we  out  1  head entry valid; write request to data memory.
- mem_addr  out  AW  word-aligned address of the head entry.
- mem_wd  out  32  lane-steered write data of the head entry.
- mem_be  out  4  byte enables of the head entry.
- mem_ready  in  1  memory accepts the write this cycle.
- st_err  out  1  registered one-cycle pulse: store rejected.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, active-high):
  - head, tail and count go to 0; every entry is invalidated; st_err goes to 0.
  - This forces mem_we=0, empty=1, st_ready=1 and ld_conflict=0.
  - Pending stores are discarded, including a reset asserted mid-drain.
- Accept condition: a store is accepted on a rising edge when st_valid && st_ready && legal.
  - legal means: st_size != 11, halfword with addr[0]==0, or word with addr[1:0]==00. Byte stores are always legal.
  - An accepted store is written at tail; tail then increments modulo DEPTH.
- Rejection: st_valid && st_ready && !legal does not enqueue; st_err is 1 for exactly the next cycle.
  - A store presented while the queue is full is neither accepted nor flagged; the datapath stalls on st_ready=0.
- Lane steering and byte enables are computed at enqueue and stored per entry. Let o = st_addr[1:0].
  - Byte: wd = {4{st_data[7:0]}}, be = 4'b0001 << o.
  - Half: wd = {2{st_data[15:0]}}, be = 4'b0011 << o.
  - Word: wd = st_data, be = 4'b1111.
  - The entry stores the address with the low two bits cleared.
- Drain:
  - mem_we = !empty.
  - mem_addr, mem_wd and mem_be are driven directly from the head entry registers.
  - The head retires when mem_we && mem_ready; head then increments modulo DEPTH.
- Latency: a store accepted at edge N appears on mem_* after edge N, provided the queue was empty. With mem_ready=1 it retires at edge N+1.
- Count and simultaneous events:
  - count += accept, count -= retire.
  - Simultaneous accept and retire leaves count unchanged.
  - When full, st_ready=0 even if a retire occurs in the same cycle; there is no combinational ready path from mem_ready.
- Order: stores are written to memory strictly in acceptance order. There is no merging or coalescing.
- Wrap-around: head and tail wrap modulo DEPTH. Full versus empty is resolved by count, not by pointer equality.
- ld_conflict:
  - Combinational; equals ld_valid && (some valid entry has addr[AW-1:2] == ld_addr[AW-1:2]).
  - Byte enables are ignored, so any overlap on the same word flags a conflict.
  - No forwarding is performed; the hazard unit stalls the load until ld_conflict falls.
- Store/load same cycle: an entry accepted on the current edge is not yet visible to ld_conflict. The compare uses only registered entries.

Test Plan:
- Reset with DEPTH=4 -> count=0, empty=1, st_ready=1, mem_we=0, st_err=0.
- Word store at 0x14, data 0xdeadc0de, mem_ready=1 -> next cycle mem_we=1, mem_addr=0x14, mem_be=1111, mem_wd=0xdeadc0de; the cycle after, empty=1.
- Byte store at 0x2b, data 0x000000ab -> mem_addr=0x28, mem_be=1000, mem_wd=0xabababab.
- Half store at 0x22, data 0x0000beef -> mem_be=1100, mem_wd=0xbeefbeef.
- Five word stores with mem_ready=0:
  - After four stores, count=4 and st_ready=0; the fifth store is held, not flagged.
  - Then mem_ready=1 -> four writes in order on consecutive cycles, and count reaches 0.
- Half store at 0x03, word store at 0x06, and st_size=11 -> each gives a one-cycle st_err pulse; count is unchanged and mem_we stays 0.
- Word store queued at 0x40 with mem_ready=0:
  - ld_valid at 0x42 -> ld_conflict=1.
  - ld_valid at 0x44 -> ld_conflict=0.
  - Assert rst mid-queue -> count=0 and ld_conflict=0 immediately, asynchronously.
